hazard_unit_mc: RTL and testbench
=================================

Name: hazard_unit_mc

Overview:
- Next-generation pipeline hazard unit for the 5-stage RISC-V core (fetch/decode/execute/mem/writeback).
- Keeps EX-stage forwarding and branch flush.
- Adds a parametrised load-use bubble count, decode operand-use qualification, and a one-entry scoreboard for a multi-cycle execute unit (mul/div).
- Sits beside the datapath; drives the forward muxes, stage stall enables and flush controls.

Parameters:
- REG_ADDR_W, 5, register index width.
- LOAD_LAT, 1, load-use bubbles inserted (legal 1..3).
- CNT_W, 2, stall counter width (must hold LOAD_LAT-1).

Ports:
- iclk  in  1  clock; all state updates on rising edge.
- irst  in  1  synchronous active-high reset.
- irs1_decod, irs2_decod  in  REG_ADDR_W  decode source regs.
- iuse_rs1_decod, iuse_rs2_decod  in  1  decode instruction actually reads rs1/rs2.
- imc_op_decod  in  1  decode instruction is a multi-cycle op.
- irs1_exect, irs2_exect, ird_exect  in  REG_ADDR_W  execute regs.
- ipc_src_exect  in  1  taken branch/jump resolved in execute.
- iresult_src_b0_exect  in  1  execute instruction is a load.
- imc_start_exect  in  1  multi-cycle op launched from execute this cycle.
- imc_done  in  1  multi-cycle unit writes its result back this cycle.
- ird_mem, ird_wrt  in  REG_ADDR_W  mem/writeback dest regs.
- ireg_wr_mem, ireg_wr_wrt  in  1  mem/writeback write enables.
- oforward_ae, oforward_be  out  2  00 regfile, 01 writeback, 10 mem.
- ostall_fetch, ostall_decod  out  1  hold PC / IF-ID register.
- oflush_decod, oflush_exect  out  1  clear IF-ID / ID-EX register.
- omc_busy  out  1  multi-cycle op outstanding.

Behaviour:
- Reset: stall counter = 0, scoreboard valid = 0, pending rd = 0, omc_busy = 0. Stall/flush outputs 0 and forward = 00 whenever inputs carry no hazard.
- Forwarding (combinational): per operand, priority mem (10) > writeback (01) > 00. A stage qualifies only if its write enable is set, its rd equals the source, and the source != 0.
- dep_ld (combinational):
  - iresult_src_b0_exect & ird_exect != 0 & ((iuse_rs1_decod & irs1_decod == ird_exect) | (iuse_rs2_decod & irs2_decod == ird_exect)).
- Load stall sequencing:
  - dep_ld in a cycle with counter = 0 stalls that cycle; counter loads LOAD_LAT-1.
  - While counter != 0: stall, decrement each cycle.
  - Total bubbles = LOAD_LAT. LOAD_LAT = 1 gives the classic single bubble.
- Scoreboard:
  - imc_start_exect sets valid = 1 and pending rd = ird_exect.
  - imc_done clears valid on the next edge.
  - Start and done in the same cycle: start wins (valid stays 1, new rd).
  - ird_exect == 0 at start: valid is set but causes no register dependency.
- dep_mc (combinational):
  - valid & pending rd != 0 & decode uses that reg, or valid & imc_op_decod (structural).
  - Release is registered: the stall persists through the imc_done cycle and drops the cycle after.
- Stall outputs:
  - stall = dep_ld | counter != 0 | dep_mc.
  - ostall_fetch = ostall_decod = stall & ~ipc_src_exect.
- Flush outputs:
  - oflush_decod = ipc_src_exect.
  - oflush_exect = ipc_src_exect | (stall & ~ipc_src_exect).
- Taken branch priority: overrides any load stall and clears the counter to 0 on the next edge. The scoreboard is not cleared, because the multi-cycle op is older than the branch.
- omc_busy = valid.
- Reset mid-operation: counter and scoreboard cleared at the edge; no residual stall.

Optional Feature:
- HAZARD_PERF_CNT_EN defined:
  - Adds outputs ostall_cnt (32) and oflush_cnt (32).
  - ostall_cnt counts cycles with ostall_decod = 1; oflush_cnt counts cycles with oflush_decod = 1.
  - Both saturate at 0xFFFFFFFF and clear on irst.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- LOAD_LAT=1, lw x5 in exect, decode add reads x5 (use=1) -> one stall cycle, oflush_exect=1 that cycle, counter stays 0. Same with iuse_rs1_decod=0 -> no stall.
- LOAD_LAT=3, same load-use -> ostall_decod=1 for exactly 3 consecutive cycles, then 0.
- LOAD_LAT=3, ipc_src_exect=1 on the 2nd stall cycle -> stall=0 and oflush_decod=oflush_exect=1 that cycle; no stall on the following cycle.
- irs1_exect=7, ird_mem=ird_wrt=7, both write enables 1 -> oforward_ae=10. With ireg_wr_mem=0 -> 01. With irs1_exect=0 -> 00.
- imc_start_exect with ird_exect=9; decode reads x9 -> stall until the cycle after imc_done, omc_busy=1 throughout. Then a second mc op in decode while busy -> structural stall.
- irst asserted during the 2nd of 3 load bubbles -> the next cycle shows counter 0, omc_busy=0, no stall. With HAZARD_PERF_CNT_EN, both counters read 0.

Source files
------------

// File: rtl/hazard_unit_mc_if.sv
// Hazard unit bus: decode/execute/mem/writeback register info in,
// forward selects, stall enables and flush controls out.
// The master modport is the datapath side, the slave modport is the hazard unit.
// Optional HAZARD_PERF_CNT_EN adds the stall/flush performance counters.
interface hazard_unit_mc_if #(
    parameter int REG_ADDR_W = 5
);
    logic [REG_ADDR_W-1:0] irs1_decod;
    logic [REG_ADDR_W-1:0] irs2_decod;
    logic                  iuse_rs1_decod;
    logic                  iuse_rs2_decod;
    logic                  imc_op_decod;
    logic [REG_ADDR_W-1:0] irs1_exect;
    logic [REG_ADDR_W-1:0] irs2_exect;
    logic [REG_ADDR_W-1:0] ird_exect;
    logic                  ipc_src_exect;
    logic                  iresult_src_b0_exect;
    logic                  imc_start_exect;
    logic                  imc_done;
    logic [REG_ADDR_W-1:0] ird_mem;
    logic [REG_ADDR_W-1:0] ird_wrt;
    logic                  ireg_wr_mem;
    logic                  ireg_wr_wrt;
    logic [1:0]            oforward_ae;
    logic [1:0]            oforward_be;
    logic                  ostall_fetch;
    logic                  ostall_decod;
    logic                  oflush_decod;
    logic                  oflush_exect;
    logic                  omc_busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]           ostall_cnt;
    logic [31:0]           oflush_cnt;
`endif

    modport master (
        output irs1_decod, irs2_decod, iuse_rs1_decod, iuse_rs2_decod, imc_op_decod,
        output irs1_exect, irs2_exect, ird_exect, ipc_src_exect, iresult_src_b0_exect,
        output imc_start_exect, imc_done, ird_mem, ird_wrt, ireg_wr_mem, ireg_wr_wrt,
        input  oforward_ae, oforward_be, ostall_fetch, ostall_decod,
        input  oflush_decod, oflush_exect, omc_busy
`ifdef HAZARD_PERF_CNT_EN
        , input ostall_cnt, oflush_cnt
`endif
    );

    modport slave (
        input  irs1_decod, irs2_decod, iuse_rs1_decod, iuse_rs2_decod, imc_op_decod,
        input  irs1_exect, irs2_exect, ird_exect, ipc_src_exect, iresult_src_b0_exect,
        input  imc_start_exect, imc_done, ird_mem, ird_wrt, ireg_wr_mem, ireg_wr_wrt,
        output oforward_ae, oforward_be, ostall_fetch, ostall_decod,
        output oflush_decod, oflush_exect, omc_busy
`ifdef HAZARD_PERF_CNT_EN
        , output ostall_cnt, oflush_cnt
`endif
    );
endinterface

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit for the 5-stage core: EX forwarding, branch flush,
// LOAD_LAT-bubble load-use stall and a one-entry scoreboard for the
// multi-cycle (mul/div) unit.
// Optional feature macro: HAZARD_PERF_CNT_EN (saturating stall/flush cycle counters).
module hazard_unit_mc #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 2
) (
    input  logic           iclk,
    input  logic           irst,
    hazard_unit_mc_if.slave hif
);

    localparam logic [CNT_W-1:0]      LD_INIT = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [REG_ADDR_W-1:0] X0 = {REG_ADDR_W{1'b0}};

    // Forward select for one operand: mem beats writeback; x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] rd_mem,
        input logic                  wr_mem,
        input logic [REG_ADDR_W-1:0] rd_wrt,
        input logic                  wr_wrt
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (src == X0) begin
            sel = 2'b00;
        end else if (wr_mem && (rd_mem == src)) begin
            sel = 2'b10;
        end else if (wr_wrt && (rd_wrt == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic                  mc_valid_q, mc_valid_d;
    logic [REG_ADDR_W-1:0] mc_rd_q,    mc_rd_d;
    logic                  dep_ld_s;
    logic                  dep_mc_s;
    logic                  stall_s;
    logic                  stall_gate_s;

    // Hazard detection: load-use and multi-cycle (data + structural) dependencies.
    always_comb begin
        dep_ld_s = 1'b0;
        dep_mc_s = 1'b0;
        dep_ld_s = hif.iresult_src_b0_exect && (hif.ird_exect != X0) &&
                   ((hif.iuse_rs1_decod && (hif.irs1_decod == hif.ird_exect)) ||
                    (hif.iuse_rs2_decod && (hif.irs2_decod == hif.ird_exect)));
        // Structural hazard: only one multi-cycle op may be in flight.
        dep_mc_s = mc_valid_q &&
                   (((mc_rd_q != X0) &&
                     ((hif.iuse_rs1_decod && (hif.irs1_decod == mc_rd_q)) ||
                      (hif.iuse_rs2_decod && (hif.irs2_decod == mc_rd_q)))) ||
                    hif.imc_op_decod);
        stall_s      = dep_ld_s || (cnt_q != CNT_ZERO) || dep_mc_s;
        // A taken branch kills the stalled instruction, so stalling is pointless.
        stall_gate_s = stall_s && !hif.ipc_src_exect;
    end

    // Output drive: forward muxes, stage holds and stage flushes.
    always_comb begin
        hif.oforward_ae  = fwd_sel(hif.irs1_exect, hif.ird_mem, hif.ireg_wr_mem,
                                   hif.ird_wrt, hif.ireg_wr_wrt);
        hif.oforward_be  = fwd_sel(hif.irs2_exect, hif.ird_mem, hif.ireg_wr_mem,
                                   hif.ird_wrt, hif.ireg_wr_wrt);
        hif.ostall_fetch = stall_gate_s;
        hif.ostall_decod = stall_gate_s;
        hif.oflush_decod = hif.ipc_src_exect;
        hif.oflush_exect = hif.ipc_src_exect || stall_gate_s;
        hif.omc_busy     = mc_valid_q;
    end

    // Next state: load bubble counter and multi-cycle scoreboard.
    always_comb begin
        cnt_d      = cnt_q;
        mc_valid_d = mc_valid_q;
        mc_rd_d    = mc_rd_q;
        if (hif.ipc_src_exect) begin
            cnt_d = CNT_ZERO;
        end else if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_ONE;
        end else if (dep_ld_s) begin
            cnt_d = LD_INIT;
        end else begin
            cnt_d = CNT_ZERO;
        end
        // A new launch outranks completion of the previous op in the same cycle.
        // The branch does not touch the scoreboard: the mc op is older than it.
        if (hif.imc_start_exect) begin
            mc_valid_d = 1'b1;
            mc_rd_d    = hif.ird_exect;
        end else if (hif.imc_done) begin
            mc_valid_d = 1'b0;
        end else begin
            mc_valid_d = mc_valid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge iclk) begin
        if (irst) begin
            cnt_q      <= CNT_ZERO;
            mc_valid_q <= 1'b0;
            mc_rd_q    <= X0;
        end else begin
            cnt_q      <= cnt_d;
            mc_valid_q <= mc_valid_d;
            mc_rd_q    <= mc_rd_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [31:0] CNT_SAT = 32'hFFFF_FFFF;

    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating counts of stalled-decode and flushed-decode cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_gate_s && (stall_cnt_q != CNT_SAT)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (hif.ipc_src_exect && (flush_cnt_q != CNT_SAT)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
        hif.ostall_cnt = stall_cnt_q;
        hif.oflush_cnt = flush_cnt_q;
    end

    // Performance counter registers with synchronous reset.
    always_ff @(posedge iclk) begin
        if (irst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc. Two instances (LOAD_LAT=1 and LOAD_LAT=3)
// receive identical stimulus; each is compared against hand-computed outputs.
// Packed observation: {fwd_a[1:0], fwd_b[1:0], stall_f, stall_d, flush_d, flush_e, busy}.
module tb_hazard_unit_mc;

    localparam logic [8:0] NONE  = 9'b00_00_0_0_0_0_0;
    localparam logic [8:0] BUSY  = 9'b00_00_0_0_0_0_1;
    localparam logic [8:0] STALL = 9'b00_00_1_1_0_1_0;
    localparam logic [8:0] STB   = 9'b00_00_1_1_0_1_1;
    localparam logic [8:0] FLUSH = 9'b00_00_0_0_1_1_0;
    localparam logic [8:0] FLB   = 9'b00_00_0_0_1_1_1;

    logic       iclk = 1'b0;
    logic       irst = 1'b1;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       use1, use2, mc_op, pc_src, is_load, mc_start, mc_done, wr_m, wr_w;
    int         vec = 0;
    int         miscmp = 0;

    always #5 iclk = ~iclk;

    hazard_unit_mc_if #(.REG_ADDR_W(5)) if1 ();
    hazard_unit_mc_if #(.REG_ADDR_W(5)) if3 ();

    hazard_unit_mc #(.REG_ADDR_W(5), .LOAD_LAT(1), .CNT_W(2)) dut1 (
        .iclk(iclk), .irst(irst), .hif(if1));
    hazard_unit_mc #(.REG_ADDR_W(5), .LOAD_LAT(3), .CNT_W(2)) dut3 (
        .iclk(iclk), .irst(irst), .hif(if3));

    assign if1.irs1_decod = rs1_d;       assign if3.irs1_decod = rs1_d;
    assign if1.irs2_decod = rs2_d;       assign if3.irs2_decod = rs2_d;
    assign if1.iuse_rs1_decod = use1;    assign if3.iuse_rs1_decod = use1;
    assign if1.iuse_rs2_decod = use2;    assign if3.iuse_rs2_decod = use2;
    assign if1.imc_op_decod = mc_op;     assign if3.imc_op_decod = mc_op;
    assign if1.irs1_exect = rs1_e;       assign if3.irs1_exect = rs1_e;
    assign if1.irs2_exect = rs2_e;       assign if3.irs2_exect = rs2_e;
    assign if1.ird_exect = rd_e;         assign if3.ird_exect = rd_e;
    assign if1.ipc_src_exect = pc_src;   assign if3.ipc_src_exect = pc_src;
    assign if1.iresult_src_b0_exect = is_load; assign if3.iresult_src_b0_exect = is_load;
    assign if1.imc_start_exect = mc_start; assign if3.imc_start_exect = mc_start;
    assign if1.imc_done = mc_done;       assign if3.imc_done = mc_done;
    assign if1.ird_mem = rd_m;           assign if3.ird_mem = rd_m;
    assign if1.ird_wrt = rd_w;           assign if3.ird_wrt = rd_w;
    assign if1.ireg_wr_mem = wr_m;       assign if3.ireg_wr_mem = wr_m;
    assign if1.ireg_wr_wrt = wr_w;       assign if3.ireg_wr_wrt = wr_w;

    wire [8:0] o1 = {if1.oforward_ae, if1.oforward_be, if1.ostall_fetch, if1.ostall_decod,
                     if1.oflush_decod, if1.oflush_exect, if1.omc_busy};
    wire [8:0] o3 = {if3.oforward_ae, if3.oforward_be, if3.ostall_fetch, if3.ostall_decod,
                     if3.oflush_decod, if3.oflush_exect, if3.omc_busy};

    task automatic clear_inputs();
        rs1_d = 5'd0; rs2_d = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0;
        rd_e = 5'd0; rd_m = 5'd0; rd_w = 5'd0;
        use1 = 1'b0; use2 = 1'b0; mc_op = 1'b0; pc_src = 1'b0; is_load = 1'b0;
        mc_start = 1'b0; mc_done = 1'b0; wr_m = 1'b0; wr_w = 1'b0;
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        irst = 1'b1;
        tick(); tick();
        irst = 1'b0;
        #1;
        vec++; if (o1 !== NONE) begin miscmp++; $display("FAIL reset dut1 got %b want %b", o1, NONE); end
        vec++; if (o3 !== NONE) begin miscmp++; $display("FAIL reset dut3 got %b want %b", o3, NONE); end
`ifdef HAZARD_PERF_CNT_EN
        vec++; if (if3.ostall_cnt !== 32'd0 || if3.oflush_cnt !== 32'd0) begin
            miscmp++; $display("FAIL reset_perf got %0d/%0d want 0/0", if3.ostall_cnt, if3.oflush_cnt); end
`endif
    endtask

    task automatic test_load_use();
        // No-hazard variants: operand not read, load to x0, non-load producer.
        tick(); clear_inputs();
        is_load = 1'b1; rd_e = 5'd5; rs1_d = 5'd5; use1 = 1'b0; #1;
        vec++; if (o1 !== NONE) begin miscmp++; $display("FAIL ld_nouse dut1 got %b want %b", o1, NONE); end
        vec++; if (o3 !== NONE) begin miscmp++; $display("FAIL ld_nouse dut3 got %b want %b", o3, NONE); end
        tick(); rd_e = 5'd0; rs1_d = 5'd0; use1 = 1'b1; #1;
        vec++; if (o3 !== NONE) begin miscmp++; $display("FAIL ld_x0 dut3 got %b want %b", o3, NONE); end
        tick(); is_load = 1'b0; rd_e = 5'd5; rs1_d = 5'd5; #1;
        vec++; if (o3 !== NONE) begin miscmp++; $display("FAIL alu_dep dut3 got %b want %b", o3, NONE); end
        // Classic load-use: lw x5 in execute, add reads x5 in decode.
        tick(); is_load = 1'b1; #1;
        vec++; if (o1 !== STALL) begin miscmp++; $display("FAIL lu_c0 dut1 got %b want %b", o1, STALL); end
        vec++; if (o3 !== STALL) begin miscmp++; $display("FAIL lu_c0 dut3 got %b want %b", o3, STALL); end
        tick(); is_load = 1'b0; rd_e = 5'd0; #1;
        vec++; if (o1 !== NONE) begin miscmp++; $display("FAIL lu_c1 dut1 got %b want %b", o1, NONE); end
        vec++; if (o3 !== STALL) begin miscmp++; $display("FAIL lu_c1 dut3 got %b want %b", o3, STALL); end
        tick();
        vec++; if (o3 !== STALL) begin miscmp++; $display("FAIL lu_c2 dut3 got %b want %b", o3, STALL); end
        tick();
        vec++; if (o3 !== NONE) begin miscmp++; $display("FAIL lu_c3 dut3 got %b want %b", o3, NONE); end
        // rs2 path, then drain the LOAD_LAT=3 counter.
        tick(); clear_inputs(); is_load = 1'b1; rd_e = 5'd6; rs2_d = 5'd6; use2 = 1'b1; #1;
        vec++; if (o1 !== STALL) begin miscmp++; $display("FAIL lu_rs2 dut1 got %b want %b", o1, STALL); end
        tick(); clear_inputs(); tick(); tick(); #1;
        vec++; if (o3 !== NONE) begin miscmp++; $display("FAIL lu_drain dut3 got %b want %b", o3, NONE); end
    endtask

    task automatic test_branch_override();
        tick(); clear_inputs();
        is_load = 1'b1; rd_e = 5'd5; rs1_d = 5'd5; use1 = 1'b1; #1;
        vec++; if (o3 !== STALL) begin miscmp++; $display("FAIL br_c0 dut3 got %b want %b", o3, STALL); end
        tick(); is_load = 1'b0; rd_e = 5'd0; pc_src = 1'b1; #1;
        vec++; if (o3 !== FLUSH) begin miscmp++; $display("FAIL br_c1 dut3 got %b want %b", o3, FLUSH); end
        vec++; if (o1 !== FLUSH) begin miscmp++; $display("FAIL br_c1 dut1 got %b want %b", o1, FLUSH); end
        tick(); pc_src = 1'b0; #1;
        vec++; if (o3 !== NONE) begin miscmp++; $display("FAIL br_after dut3 got %b want %b", o3, NONE); end
    endtask

    task automatic test_forward();
        tick(); clear_inputs();
        rs1_e = 5'd7; rs2_e = 5'd3; rd_m = 5'd7; rd_w = 5'd7; wr_m = 1'b1; wr_w = 1'b1; #1;
        vec++; if (o1 !== 9'b10_00_0_0_0_0_0) begin miscmp++; $display("FAIL fwd_mem got %b want %b", o1, 9'b10_00_0_0_0_0_0); end
        wr_m = 1'b0; #1;
        vec++; if (o1 !== 9'b01_00_0_0_0_0_0) begin miscmp++; $display("FAIL fwd_wb got %b want %b", o1, 9'b01_00_0_0_0_0_0); end
        rs1_e = 5'd0; rd_m = 5'd0; rd_w = 5'd0; wr_m = 1'b1; #1;
        vec++; if (o3 !== NONE) begin miscmp++; $display("FAIL fwd_x0 got %b want %b", o3, NONE); end
        rs1_e = 5'd3; rs2_e = 5'd7; rd_m = 5'd7; rd_w = 5'd3; #1;
        vec++; if (o3 !== 9'b01_10_0_0_0_0_0) begin miscmp++; $display("FAIL fwd_split got %b want %b", o3, 9'b01_10_0_0_0_0_0); end
        wr_m = 1'b0; wr_w = 1'b0; #1;
        vec++; if (o1 !== NONE) begin miscmp++; $display("FAIL fwd_nowr got %b want %b", o1, NONE); end
    endtask

    task automatic test_multicycle();
        tick(); clear_inputs();
        mc_start = 1'b1; rd_e = 5'd9; rs1_d = 5'd9; use1 = 1'b1; #1;
        vec++; if (o1 !== NONE) begin miscmp++; $display("FAIL mc_start got %b want %b", o1, NONE); end
        tick(); mc_start = 1'b0; rd_e = 5'd0; #1;
        vec++; if (o1 !== STB) begin miscmp++; $display("FAIL mc_dep0 got %b want %b", o1, STB); end
        tick();
        vec++; if (o3 !== STB) begin miscmp++; $display("FAIL mc_dep1 got %b want %b", o3, STB); end
        tick(); mc_done = 1'b1; #1;
        vec++; if (o1 !== STB) begin miscmp++; $display("FAIL mc_donecyc got %b want %b", o1, STB); end
        tick(); mc_done = 1'b0; #1;
        vec++; if (o1 !== NONE) begin miscmp++; $display("FAIL mc_release got %b want %b", o1, NONE); end
        // Launch to x0: busy without a register dependency, then structural stall.
        tick(); mc_start = 1'b1; rd_e = 5'd0; rs1_d = 5'd0; #1;
        tick(); mc_start = 1'b0; #1;
        vec++; if (o1 !== BUSY) begin miscmp++; $display("FAIL mc_x0 got %b want %b", o1, BUSY); end
        mc_op = 1'b1; #1;
        vec++; if (o3 !== STB) begin miscmp++; $display("FAIL mc_struct got %b want %b", o3, STB); end
        // Start and done together: start wins, new rd tracked.
        mc_op = 1'b0; mc_start = 1'b1; mc_done = 1'b1; rd_e = 5'd4; rs1_d = 5'd4; #1;
        vec++; if (o1 !== BUSY) begin miscmp++; $display("FAIL mc_sd_cyc got %b want %b", o1, BUSY); end
        tick(); mc_start = 1'b0; mc_done = 1'b0; rd_e = 5'd0; #1;
        vec++; if (o1 !== STB) begin miscmp++; $display("FAIL mc_sd_win got %b want %b", o1, STB); end
        // Branch flushes but leaves the scoreboard intact.
        pc_src = 1'b1; #1;
        vec++; if (o1 !== FLB) begin miscmp++; $display("FAIL mc_br got %b want %b", o1, FLB); end
        tick(); pc_src = 1'b0; #1;
        vec++; if (o3 !== STB) begin miscmp++; $display("FAIL mc_br_keep got %b want %b", o3, STB); end
        mc_done = 1'b1;
        tick(); mc_done = 1'b0; #1;
        vec++; if (o3 !== NONE) begin miscmp++; $display("FAIL mc_end got %b want %b", o3, NONE); end
    endtask

    task automatic test_reset_mid();
        tick(); clear_inputs(); mc_start = 1'b1; rd_e = 5'd12;
        tick(); mc_start = 1'b0; is_load = 1'b1; rd_e = 5'd5; rs1_d = 5'd5; use1 = 1'b1; #1;
        vec++; if (o3 !== STB) begin miscmp++; $display("FAIL rm_c0 dut3 got %b want %b", o3, STB); end
        tick(); is_load = 1'b0; rd_e = 5'd0; #1;
        vec++; if (o3 !== STB) begin miscmp++; $display("FAIL rm_c1 dut3 got %b want %b", o3, STB); end
        vec++; if (o1 !== BUSY) begin miscmp++; $display("FAIL rm_c1 dut1 got %b want %b", o1, BUSY); end
        irst = 1'b1;
        tick(); irst = 1'b0; #1;
        vec++; if (o3 !== NONE) begin miscmp++; $display("FAIL rm_after dut3 got %b want %b", o3, NONE); end
        vec++; if (o1 !== NONE) begin miscmp++; $display("FAIL rm_after dut1 got %b want %b", o1, NONE); end
`ifdef HAZARD_PERF_CNT_EN
        vec++; if (if3.ostall_cnt !== 32'd0 || if3.oflush_cnt !== 32'd0) begin
            miscmp++; $display("FAIL rm_perf got %0d/%0d want 0/0", if3.ostall_cnt, if3.oflush_cnt); end
`endif
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_cnt();
        clear_inputs(); irst = 1'b1;
        tick(); irst = 1'b0;
        is_load = 1'b1; rd_e = 5'd5; rs1_d = 5'd5; use1 = 1'b1;
        tick(); is_load = 1'b0; rd_e = 5'd0;
        tick(); tick(); pc_src = 1'b1;
        tick(); pc_src = 1'b0; #1;
        vec++; if (if1.ostall_cnt !== 32'd1) begin miscmp++; $display("FAIL perf_stall dut1 got %0d want 1", if1.ostall_cnt); end
        vec++; if (if3.ostall_cnt !== 32'd3) begin miscmp++; $display("FAIL perf_stall dut3 got %0d want 3", if3.ostall_cnt); end
        vec++; if (if3.oflush_cnt !== 32'd1) begin miscmp++; $display("FAIL perf_flush dut3 got %0d want 1", if3.oflush_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_branch_override();
        test_forward();
        test_multicycle();
        test_reset_mid();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
